// File: rtl/tiger_dmem_bridge_if.sv
// Tiger data-memory port bundle: core request/response side plus the Avalon-MM master side.
// The bridge uses the master modport; the core/slave environment uses the slave modport.
interface tiger_dmem_bridge_if;
  logic        memread;
  logic        memwrite;
  logic        mem16;
  logic        mem8;
  logic        memzerofill;
  logic [31:0] memaddress;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        memCanRead;
  logic        memCanWrite;
  logic        dStall;

  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  logic        misalign_err;
  logic        bus_err;

  modport master (
    input  memread, memwrite, mem16, mem8, memzerofill, memaddress, memwritedata,
    output memreaddata, memCanRead, memCanWrite, dStall,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid,
    output misalign_err, bus_err
  );

  modport slave (
    output memread, memwrite, mem16, mem8, memzerofill, memaddress, memwritedata,
    input  memreaddata, memCanRead, memCanWrite, dStall,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  misalign_err, bus_err
  );
endinterface

// File: rtl/tiger_dmem_bridge.sv
// Bridges the Tiger core data-memory port to a single-outstanding Avalon-MM master,
// stalling the core per access and returning lane-aligned, extended read data.
module tiger_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input logic                 clk,
  input logic                 reset,
  tiger_dmem_bridge_if.master dmem_io
);

  typedef enum logic [2:0] {StIdle, StWr, StRd, StRwait, StDone} state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q;
  logic [31:0]       avm_address_q;
  logic [31:0]       avm_writedata_q;
  logic [3:0]        avm_byteenable_q;
  logic              avm_read_q;
  logic              avm_write_q;
  logic [31:0]       memreaddata_q;
  logic              misalign_err_q;
  logic              bus_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        lane_q;
  logic              is_byte_q;
  logic              is_half_q;
  logic              zfill_q;

  logic              req;
  logic              is_byte;
  logic              is_half;
  logic [1:0]        lane;
  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wd_new;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  // Shift the addressed lane down, then extend according to the registered access size.
  function automatic logic [31:0] extend_rd(input logic [31:0] d, input logic [1:0] ln,
                                            input logic is_b, input logic is_h,
                                            input logic zf);
    logic [31:0] s;
    s = d >> {ln, 3'b000};
    if (is_b) begin
      return zf ? {24'h0, s[7:0]} : {{24{s[7]}}, s[7:0]};
    end else if (is_h) begin
      return zf ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    end
    return s;
  endfunction

  always_comb begin
    req        = dmem_io.memread | dmem_io.memwrite;
    is_byte    = dmem_io.mem8;
    is_half    = ~dmem_io.mem8 & dmem_io.mem16;
    lane       = dmem_io.memaddress[1:0];
    misaligned = is_half ? lane[0] : (~is_byte & (lane != 2'b00));
    be_new     = 4'b1111;
    wd_new     = dmem_io.memwritedata;
    if (is_byte) begin
      be_new = 4'b0001 << lane;
      wd_new = {4{dmem_io.memwritedata[7:0]}};
    end else if (is_half) begin
      be_new = lane[1] ? 4'b1100 : 4'b0011;
      wd_new = {2{dmem_io.memwritedata[15:0]}};
    end
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TimeoutVal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= StIdle;
      avm_address_q    <= '0;
      avm_writedata_q  <= '0;
      avm_byteenable_q <= '0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      memreaddata_q    <= '0;
      misalign_err_q   <= 1'b0;
      bus_err_q        <= 1'b0;
      cnt_q            <= '0;
      lane_q           <= '0;
      is_byte_q        <= 1'b0;
      is_half_q        <= 1'b0;
      zfill_q          <= 1'b0;
    end else begin
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            if (misaligned) begin
              misalign_err_q <= 1'b1;
              memreaddata_q  <= '0;
              state_q        <= StDone;
            end else begin
              avm_address_q    <= {dmem_io.memaddress[31:2], 2'b00};
              avm_byteenable_q <= be_new;
              avm_writedata_q  <= wd_new;
              lane_q           <= lane;
              is_byte_q        <= is_byte;
              is_half_q        <= is_half;
              zfill_q          <= dmem_io.memzerofill;
              cnt_q            <= '0;
              // A read wins if the core ever raises both requests.
              if (dmem_io.memread) begin
                avm_read_q <= 1'b1;
                state_q    <= StRd;
              end else begin
                avm_write_q <= 1'b1;
                state_q     <= StWr;
              end
            end
          end
        end
        StWr: begin
          cnt_q <= cnt_inc;
          if (!dmem_io.avm_waitrequest) begin
            avm_write_q <= 1'b0;
            state_q     <= StDone;
          end else if (timeout_hit) begin
            avm_write_q   <= 1'b0;
            bus_err_q     <= 1'b1;
            memreaddata_q <= '1;
            state_q       <= StDone;
          end
        end
        StRd: begin
          cnt_q <= cnt_inc;
          if (!dmem_io.avm_waitrequest) begin
            avm_read_q <= 1'b0;
            if (dmem_io.avm_readdatavalid) begin
              memreaddata_q <= extend_rd(dmem_io.avm_readdata, lane_q, is_byte_q, is_half_q,
                                         zfill_q);
              state_q       <= StDone;
            end else begin
              state_q <= StRwait;
            end
          end else if (timeout_hit) begin
            avm_read_q    <= 1'b0;
            bus_err_q     <= 1'b1;
            memreaddata_q <= '1;
            state_q       <= StDone;
          end
        end
        StRwait: begin
          cnt_q <= cnt_inc;
          if (dmem_io.avm_readdatavalid) begin
            memreaddata_q <= extend_rd(dmem_io.avm_readdata, lane_q, is_byte_q, is_half_q,
                                       zfill_q);
            state_q       <= StDone;
          end else if (timeout_hit) begin
            bus_err_q     <= 1'b1;
            memreaddata_q <= '1;
            state_q       <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dmem_io.dStall         = (state_q == StIdle) ? req : (state_q != StDone);
  assign dmem_io.memCanRead     = (state_q == StIdle);
  assign dmem_io.memCanWrite    = (state_q == StIdle);
  assign dmem_io.memreaddata    = memreaddata_q;
  assign dmem_io.avm_address    = avm_address_q;
  assign dmem_io.avm_read       = avm_read_q;
  assign dmem_io.avm_write      = avm_write_q;
  assign dmem_io.avm_byteenable = avm_byteenable_q;
  assign dmem_io.avm_writedata  = avm_writedata_q;
  assign dmem_io.misalign_err   = misalign_err_q;
  assign dmem_io.bus_err        = bus_err_q;

endmodule

// File: tb/tb_tiger_dmem_bridge.sv
// Scoreboard bench for tiger_dmem_bridge: a core/slave model issues accesses, pushes expected
// results at issue time and pops them when the bridge completes.
module tb_tiger_dmem_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tiger_dmem_bridge_if dmem ();

  tiger_dmem_bridge #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (4)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .dmem_io(dmem)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_exp_t;

  logic [31:0] rd_q[$];
  wr_exp_t     wr_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] d, input logic [1:0] a,
                                           input bit m16, input bit m8, input bit zf);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    if (m8) return zf ? {24'h0, b} : {{24{b[7]}}, b};
    if (m16) return zf ? {16'h0, h} : {{16{h[15]}}, h};
    return d;
  endfunction

  function automatic wr_exp_t model_wr(input logic [31:0] a, input logic [31:0] d,
                                       input bit m16, input bit m8);
    wr_exp_t e;
    e.addr = {a[31:2], 2'b00};
    if (m8) begin
      case (a[1:0])
        2'd0:    e.be = 4'b0001;
        2'd1:    e.be = 4'b0010;
        2'd2:    e.be = 4'b0100;
        default: e.be = 4'b1000;
      endcase
      e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
    end else if (m16) begin
      e.be   = a[1] ? 4'b1100 : 4'b0011;
      e.data = {d[15:0], d[15:0]};
    end else begin
      e.be   = 4'b1111;
      e.data = d;
    end
    return e;
  endfunction

  // One core access against a slave that holds waitrequest for `waits` cycles and returns
  // readdatavalid one cycle after acceptance when give_rdv is set. exp_stall < 0 skips that check.
  task automatic access(input string tag, input bit rd, input bit wr, input bit m16,
                        input bit m8, input bit zf, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                        input bit give_rdv, input int exp_stall, input bit exp_mis,
                        input bit exp_berr);
    int      stall = 0;
    int      wl = waits;
    bit      pend = 0;
    bit      done = 0;
    bit      saw_rd = 0;
    bit      saw_wr = 0;
    wr_exp_t e;
    if (exp_mis) rd_q.push_back(32'h0);
    else if (exp_berr) rd_q.push_back(32'hFFFF_FFFF);
    else if (rd) rd_q.push_back(model_rd(rdata, addr[1:0], m16, m8, zf));
    if (wr && !rd && !exp_mis) wr_q.push_back(model_wr(addr, wdata, m16, m8));

    dmem.memread      = rd;
    dmem.memwrite     = wr;
    dmem.mem16        = m16;
    dmem.mem8         = m8;
    dmem.memzerofill  = zf;
    dmem.memaddress   = addr;
    dmem.memwritedata = wdata;
    for (int c = 0; c < 64 && !done; c++) begin
      dmem.avm_readdatavalid = pend & give_rdv;
      dmem.avm_readdata      = (pend & give_rdv) ? rdata : 32'h0;
      pend = 0;
      if ((dmem.avm_read || dmem.avm_write) && wl > 0) begin
        dmem.avm_waitrequest = 1'b1;
        wl--;
      end else begin
        dmem.avm_waitrequest = 1'b0;
      end
      if (dmem.avm_read) saw_rd = 1;
      if (dmem.avm_write) saw_wr = 1;
      if (dmem.avm_read && !dmem.avm_waitrequest) pend = 1;
      if (dmem.avm_write && !dmem.avm_waitrequest) begin
        if (wr_q.size() > 0) begin
          e = wr_q.pop_front();
          check({tag, "_addr"}, dmem.avm_address, e.addr);
          check({tag, "_be"}, 32'(dmem.avm_byteenable), 32'(e.be));
          check({tag, "_wdata"}, dmem.avm_writedata, e.data);
        end else begin
          check({tag, "_unexpected_write"}, 32'(1), 32'(0));
        end
      end
      #1;
      if (dmem.dStall) begin
        stall++;
        step();
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      check({tag, "_hang"}, 32'(0), 32'(1));
    end else begin
      if (exp_stall >= 0) check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
      check({tag, "_misalign"}, 32'(dmem.misalign_err), 32'(exp_mis));
      check({tag, "_buserr"}, 32'(dmem.bus_err), 32'(exp_berr));
      if (rd || exp_mis) begin
        if (rd_q.size() > 0) check({tag, "_rdata"}, dmem.memreaddata, rd_q.pop_front());
        else check({tag, "_rdq_empty"}, 32'(1), 32'(0));
      end
      if (exp_mis) check({tag, "_nobus"}, 32'(saw_rd | saw_wr), 32'(0));
      if (rd) check({tag, "_nowrite"}, 32'(saw_wr), 32'(0));
      step();
      check({tag, "_pulse"}, 32'(dmem.misalign_err | dmem.bus_err), 32'(0));
      check({tag, "_canread"}, 32'(dmem.memCanRead & dmem.memCanWrite), 32'(1));
    end
    dmem.memread           = 1'b0;
    dmem.memwrite          = 1'b0;
    dmem.avm_waitrequest   = 1'b0;
    dmem.avm_readdatavalid = 1'b0;
    dmem.avm_readdata      = 32'h0;
  endtask

  initial begin
    dmem.memread           = 1'b0;
    dmem.memwrite          = 1'b0;
    dmem.mem16             = 1'b0;
    dmem.mem8              = 1'b0;
    dmem.memzerofill       = 1'b0;
    dmem.memaddress        = 32'h0;
    dmem.memwritedata      = 32'h0;
    dmem.avm_waitrequest   = 1'b0;
    dmem.avm_readdata      = 32'h0;
    dmem.avm_readdatavalid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check("rst_dstall", 32'(dmem.dStall), 32'(0));
    check("rst_can", 32'(dmem.memCanRead & dmem.memCanWrite), 32'(1));
    check("rst_strobes", 32'({dmem.avm_read, dmem.avm_write}), 32'(0));
    check("rst_be", 32'(dmem.avm_byteenable), 32'(0));
    check("rst_addr", dmem.avm_address, 32'h0);
    check("rst_rdata", dmem.memreaddata, 32'h0);

    //     tag          rd wr 16 8 zf addr          wdata         w  rdata         v  st mis be
    access("sb",        0, 1, 0, 1, 0, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0,        0, 2, 0, 0);
    access("lb_s",      1, 0, 0, 1, 0, 32'h0000_2002, 32'h0,        0, 32'h0080_FF00, 1, 3, 0, 0);
    access("lb_z",      1, 0, 0, 1, 1, 32'h0000_2002, 32'h0,        0, 32'h0080_FF00, 1, 3, 0, 0);
    access("lh_s",      1, 0, 1, 0, 0, 32'h0000_3002, 32'h0,        0, 32'h8001_1234, 1, 3, 0, 0);
    access("lh_w3",     1, 0, 1, 0, 0, 32'h0000_3002, 32'h0,        3, 32'h8001_1234, 1, 6, 0, 0);
    access("lw_mis",    1, 0, 0, 0, 0, 32'h0000_4001, 32'h0,        0, 32'h0,        0, 1, 1, 0);
    access("sh_mis",    0, 1, 1, 0, 0, 32'h0000_4003, 32'h0000_BEEF, 0, 32'h0,        0, 1, 1, 0);
    access("rw_both",   1, 1, 0, 0, 0, 32'h0000_5000, 32'h1111_2222, 0, 32'h1234_5678, 1, 3, 0, 0);
    access("sh_hi_w2",  0, 1, 1, 0, 0, 32'h0000_5006, 32'h0000_C0DE, 2, 32'h0,        0, 4, 0, 0);

    for (int i = 0; i < 8; i++) begin
      int          sz;
      bit          r;
      bit          z;
      int          w;
      logic [1:0]  ln;
      logic [31:0] a;
      logic [31:0] d;
      sz = $urandom_range(0, 2);
      r  = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 2);
      ln = (sz == 0) ? 2'($urandom_range(0, 3)) : (sz == 1) ? {1'($urandom_range(0, 1)), 1'b0}
                                                            : 2'b00;
      a  = 32'h0000_8000 + 32'(i << 4) + 32'(ln);
      d  = $urandom;
      access($sformatf("rnd%0d", i), r, !r, sz == 1, sz == 0, z, a, d, w, d, 1,
             r ? 3 + w : 2 + w, 0, 0);
    end

    access("to_rd",     1, 0, 0, 0, 0, 32'h0000_6000, 32'h0,        0, 32'h0,        0, -1, 0, 1);
    access("sw_after",  0, 1, 0, 0, 0, 32'h0000_6004, 32'hCAFE_F00D, 0, 32'h0,        0, 2, 0, 0);

    // Reset while waiting for read data; a stray readdatavalid afterwards must be ignored.
    dmem.memread    = 1'b1;
    dmem.mem16      = 1'b0;
    dmem.mem8       = 1'b0;
    dmem.memaddress = 32'h0000_7000;
    step();
    check("mr_read_issued", 32'(dmem.avm_read), 32'(1));
    step();
    reset        = 1'b1;
    dmem.memread = 1'b0;
    step();
    check("mr_dstall", 32'(dmem.dStall), 32'(0));
    check("mr_read", 32'(dmem.avm_read), 32'(0));
    check("mr_idle", 32'(dmem.memCanRead), 32'(1));
    check("mr_rdata", dmem.memreaddata, 32'h0);
    reset                  = 1'b0;
    dmem.avm_readdatavalid = 1'b1;
    dmem.avm_readdata      = 32'hDEAD_BEEF;
    step();
    dmem.avm_readdatavalid = 1'b0;
    step();
    check("mr_stray_rdv", dmem.memreaddata, 32'h0);
    check("mr_stray_dstall", 32'(dmem.dStall), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tiger_dmem_bridge.md
Name: tiger_dmem_bridge

Overview:
- Sits directly downstream of the Tiger core's data-memory port.
- Converts the core's memread/memwrite/mem16/mem8/memzerofill request into a single-outstanding Avalon-MM master transaction.
- Drives dStall back to the core until each access completes, and returns lane-aligned, sign- or zero-extended read data.
- Also flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles allowed from command issue to completion before abort; 0 disables the timeout.
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- memread  in  1  core read request, held stable while dStall is high
- memwrite  in  1  core write request, held stable while dStall is high
- mem16  in  1  halfword access
- mem8  in  1  byte access (mem16=mem8=0 means word)
- memzerofill  in  1  zero-extend sub-word reads (0 = sign-extend)
- memaddress  in  32  byte address
- memwritedata  in  32  write data, right-justified
- memreaddata  out  32  aligned and extended read result
- memCanRead  out  1  bridge idle, a read may be issued
- memCanWrite  out  1  bridge idle, a write may be issued
- dStall  out  1  stall request to the core
- avm_address  out  32  word-aligned bus address
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_byteenable  out  4  byte lanes
- avm_writedata  out  32  lane-replicated write data
- avm_waitrequest  in  1  slave back-pressure
- avm_readdata  in  32  slave read data
- avm_readdatavalid  in  1  read data strobe
- misalign_err  out  1  one-cycle pulse on a misaligned request
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset values:
  - State IDLE.
  - All avm_* strobes 0; avm_address, avm_writedata and avm_byteenable 0.
  - memreaddata 0; dStall 0; memCanRead = memCanWrite = 1; both error pulses 0; counter 0.
- FSM states: IDLE, WR, RD, RWAIT, DONE.
- If memread and memwrite are both high, the read wins. This is never legal from the core; the bench checks it is handled deterministically.
- Clock and reset use the same names as the core (clk, reset).
- IDLE:
  - dStall = memread|memwrite (combinational, same cycle).
  - memCanRead/memCanWrite are 1 only in IDLE.
  - On a request, check alignment:
    - Misaligned means a halfword with addr[0]=1, or a word with addr[1:0]!=0.
    - On misalignment: pulse misalign_err, set memreaddata=0, go to DONE; no bus cycle.
  - Otherwise register address/lanes/data and the extension mode, then go to WR (write) or RD (read). avm_* asserts on the next edge.
- Lane rules:
  - avm_address = {addr[31:2],2'b00}.
  - Byte: byteenable = 4'b0001<<addr[1:0]; writedata = {4{d[7:0]}}.
  - Halfword: byteenable = addr[1] ? 4'b1100 : 4'b0011; writedata = {2{d[15:0]}}.
  - Word: byteenable = 4'b1111; writedata = d.
- WR:
  - Hold avm_write and fields while avm_waitrequest=1.
  - On the edge where waitrequest=0: drop avm_write and go to DONE.
- RD:
  - Hold avm_read while waitrequest=1.
  - When accepted: drop avm_read and go to RWAIT.
  - If readdatavalid arrives in the acceptance cycle, capture it and go straight to DONE.
- RWAIT:
  - On avm_readdatavalid, capture the data and go to DONE.
  - Capture rule: shift the selected lane down by addr[1:0]*8, then zero-extend if memzerofill, else sign-extend from bit 7 (byte) or bit 15 (halfword). Word data passes unchanged.
- DONE:
  - dStall=0 for exactly this cycle, so the core advances.
  - Return to IDLE next cycle.
  - memreaddata holds until the next read capture or misalign.
- Latency with zero waitrequest and readdatavalid one cycle after acceptance:
  - Write: dStall high for 2 cycles (IDLE, WR).
  - Read: dStall high for 3 cycles (IDLE, RD, RWAIT).
- Timeout:
  - The counter clears on entering WR/RD and increments each cycle in WR/RD/RWAIT.
  - When it reaches TIMEOUT_CYCLES (if nonzero): drop all strobes, pulse bus_err, set memreaddata=0xFFFFFFFF, go to DONE.
  - A late readdatavalid arriving in IDLE is ignored.
- A request that is already high in DONE is not sampled until IDLE, so each request completes exactly once.
- A synchronous reset mid-transaction forces IDLE and the reset values next edge, even if the slave is still busy.

Test Plan:
1. Byte store: addr 0x1003, data 0x000000A5 -> avm_byteenable=1000, avm_writedata=0xA5A5A5A5, avm_address=0x1000; dStall high 2 cycles with waitrequest=0.
2. Signed byte load: addr 0x2002, memzerofill=0, slave returns 0x0080FF00 -> memreaddata=0xFFFFFF80. Repeat with memzerofill=1 -> 0x00000080.
3. Halfword load: addr 0x3002, sign-extend, slave returns 0x8001_1234 -> memreaddata=0xFFFF8001. Add 3 waitrequest cycles -> dStall extends exactly 3 cycles.
4. Misaligned word load at 0x4001 -> misalign_err pulses once, no avm_read ever asserted, memreaddata=0, dStall high 1 cycle.
5. Timeout with TIMEOUT_CYCLES=8 and no readdatavalid -> bus_err pulse, memreaddata=0xFFFFFFFF, bridge back in IDLE; a following word write succeeds normally.
6. Reset asserted in RWAIT -> next cycle state IDLE, dStall=0, avm_read=0; a stray readdatavalid afterwards leaves memreaddata=0.
